seg_display_scan: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver for the board's common-anode display bank. It scans `N_DIGITS` hex digits and generates its refresh tick from an internal prescaler, so the scan logic needs no derived clock. Updates are tear-free through a double buffer, and the block adds per-digit decimal points, leading-zero blanking and 16-level PWM brightness. It sits between the datapath (value producer) and the top-level pins.

---
 rtl/seg_display_scan.sv | 126 ++++++++++++
 tb/tb_seg_display_scan.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
// Time-multiplexed common-anode seven-segment driver with a prescaled scan,
// double-buffered digits, leading-zero blanking and 16-level brightness.
module seg_display_scan #(
  parameter int N_DIGITS = 4,
  parameter int TICK_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [3:0]            bright,
  output logic [0:6]            sseg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CMAX = CW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(N_DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [3:0]            phase;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] pend_val;
  logic [4*N_DIGITS-1:0] act_val;
  logic [N_DIGITS-1:0]   pend_dp;
  logic [N_DIGITS-1:0]   act_dp;

  logic                  tick;
  logic                  slot_end;
  logic                  wrap;
  logic [3:0]            nib;
  logic [N_DIGITS-1:0]   lz;
  logic                  nz;
  logic [0:6]            sseg_n;
  logic                  dp_n;
  logic [N_DIGITS-1:0]   an_n;

  function automatic logic [0:6] glyph(input logic [3:0] h);
    logic [0:6] g;
    unique case (h)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      4'hF: g = 7'b0111000;
    endcase
    return g;
  endfunction

  assign tick     = (cnt == CMAX);
  assign slot_end = tick && (phase == 4'hF);
  assign wrap     = slot_end && (idx == IMAX);

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    lz = '0;
    nz = 1'b0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      nz    = nz | (|act_val[4*i +: 4]);
      lz[i] = ~nz;
    end
  end

  always_comb begin
    nib    = act_val[4*idx +: 4];
    sseg_n = glyph(nib);
    if (blank_lz && lz[idx])
      sseg_n = 7'b1111111;
    dp_n = ~act_dp[idx];
    an_n = '1;
    if (phase <= bright)
      an_n[idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      phase      <= '0;
      idx        <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      act_val    <= '0;
      act_dp     <= '0;
      sseg       <= 7'b1111111;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick)
        phase <= phase + 1'b1;
      if (slot_end)
        idx <= (idx == IMAX) ? '0 : idx + 1'b1;
      // A load landing on the wrap edge waits for the next frame.
      if (wrap) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
      end
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
      end
      sseg       <= sseg_n;
      dp         <= dp_n;
      an         <= an_n;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with N_DIGITS=4, TICK_DIV=4
// (64-clock slots, 256-clock frames).
module tb_seg_display_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  bright;
  logic [0:6]  sseg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int on_cnt;

  seg_display_scan #(
    .N_DIGITS(4),
    .TICK_DIV(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .dp_in     (dp_in),
    .load      (load),
    .blank_lz  (blank_lz),
    .bright    (bright),
    .sseg      (sseg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Edges since reset release: cyc==k at the negedge after the k-th edge.
  always @(posedge clk)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic goto(input int k);
    int n;
    n = 0;
    while (cyc != k && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != k) begin
      checks++;
      errors++;
      $display("FAIL goto_%0d got %0d exp %0d", k, cyc, k);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; value = '0; dp_in = '0; load = 1'b0;
    blank_lz = 1'b0; bright = 4'd15;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_an", an, 4'b1111);
    chk("rst_sseg", sseg, 7'b1111111);
    chk("rst_dp", dp, 1'b1);
    chk("rst_fd", frame_done, 1'b0);
    rst = 1'b0;

    goto(1);
    chk("s0_an", an, 4'b1110);
    chk("s0_sseg", sseg, 7'b0000001);

    goto(10);
    do_load(16'hA810, 4'b0100);

    goto(64);
    chk("s0_end_an", an, 4'b1110);
    goto(65);
    chk("s1_an", an, 4'b1101);
    goto(70);
    chk("noload_sseg", sseg, 7'b0000001);
    goto(255);
    chk("fd_pre", frame_done, 1'b0);
    goto(256);
    chk("fd", frame_done, 1'b1);
    chk("old_s3", sseg, 7'b0000001);
    goto(257);
    chk("fd_post", frame_done, 1'b0);

    goto(258);
    chk("f1_d0", sseg, 7'b0000001);
    chk("f1_an0", an, 4'b1110);
    chk("f1_dp0", dp, 1'b1);
    goto(322);
    chk("f1_d1", sseg, 7'b1001111);
    chk("f1_an1", an, 4'b1101);
    goto(386);
    chk("f1_d2", sseg, 7'b0000000);
    chk("f1_an2", an, 4'b1011);
    chk("f1_dp2", dp, 1'b0);
    goto(450);
    chk("f1_d3", sseg, 7'b0001000);
    chk("f1_an3", an, 4'b0111);
    chk("f1_dp3", dp, 1'b1);

    goto(460);
    blank_lz = 1'b1;
    do_load(16'h0030, 4'b1000);
    goto(514);
    chk("lz_d0", sseg, 7'b0000001);
    goto(578);
    chk("lz_d1", sseg, 7'b0000110);
    goto(642);
    chk("lz_d2", sseg, 7'b1111111);
    goto(706);
    chk("lz_d3", sseg, 7'b1111111);
    chk("lz_dp3", dp, 1'b0);
    goto(710);
    do_load(16'h0000, 4'b0000);
    goto(771);
    chk("z_d0", sseg, 7'b0000001);
    goto(835);
    chk("z_d1", sseg, 7'b1111111);
    goto(963);
    chk("z_d3", sseg, 7'b1111111);

    goto(1000);
    blank_lz = 1'b0;
    bright = 4'd3;
    on_cnt = 0;
    for (int k = 1025; k <= 1088; k++) begin
      goto(k);
      if (an != 4'b1111) on_cnt++;
      if (k == 1040) chk("b3_last_on", an, 4'b1110);
      if (k == 1041) chk("b3_first_off", an, 4'b1111);
    end
    chk("b3_on", on_cnt, 16);
    bright = 4'd15;
    on_cnt = 0;
    for (int k = 1089; k <= 1152; k++) begin
      goto(k);
      if (an != 4'b1111) on_cnt++;
    end
    chk("b15_on", on_cnt, 64);

    goto(1160);
    do_load(16'h2222, 4'b0000);
    goto(1279);
    value = 16'h1111;
    load = 1'b1;
    goto(1280);
    load = 1'b0;
    goto(1282);
    chk("wrap_f5_d0", sseg, 7'b0010010);
    goto(1474);
    chk("wrap_f5_d3", sseg, 7'b0010010);
    goto(1538);
    chk("wrap_f6_d0", sseg, 7'b1001111);

    goto(1680);
    chk("mid_an", an, 4'b1011);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_an", an, 4'b1111);
    chk("mid_rst_sseg", sseg, 7'b1111111);
    rst = 1'b0;
    goto(1);
    chk("rs_an", an, 4'b1110);
    chk("rs_sseg", sseg, 7'b0000001);
    goto(256);
    chk("rs_fd", frame_done, 1'b1);
    goto(258);
    chk("rs_pend", sseg, 7'b0000001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
